// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider: one restoring shift-subtract step per clock,
// followed by a sign-fixup cycle and a one-cycle done pulse.
module div_unit (
  input  logic        div_clk,
  input  logic        div_rst_n,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic        mode_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] dvsr;
  logic [31:0] quo;
  logic [31:0] rem;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] q_fixed;
  logic [31:0] r_fixed;
  logic [31:0] r_zero;

  // quo starts as |dividend| and fills with quotient bits as the dividend shifts out.
  always_comb begin
    a_mag   = (div_signed && dividend[31]) ? -dividend : dividend;
    b_mag   = (div_signed && divisor[31])  ? -divisor  : divisor;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvsr};
    q_fixed = (mode_signed && (neg_a ^ neg_b)) ? -quo : quo;
    r_fixed = (mode_signed && neg_a) ? -rem : rem;
    // Re-applying the sign to |dividend| restores the original dividend bit pattern.
    r_zero  = (mode_signed && neg_a) ? -quo : quo;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears all state, including the working registers.
  always_ff @(posedge div_clk or negedge div_rst_n) begin
    if (!div_rst_n) begin
      state       <= ST_IDLE;
      count       <= 6'd0;
      mode_signed <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dvsr        <= 32'd0;
      quo         <= 32'd0;
      rem         <= 32'd0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_start && !div_cancel) begin
            state       <= ST_RUN;
            mode_signed <= div_signed;
            neg_a       <= div_signed & dividend[31];
            neg_b       <= div_signed & divisor[31];
            quo         <= a_mag;
            dvsr        <= b_mag;
            rem         <= 32'd0;
            count       <= 6'd0;
            div_by_zero <= 1'b0;
          end
        end
        ST_RUN: begin
          if (div_cancel) begin
            state <= ST_IDLE;
          end else if (dvsr == 32'd0) begin
            state       <= ST_DONE;
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= r_zero;
            div_by_zero <= 1'b1;
          end else begin
            // A clear borrow bit means the shifted remainder covers the divisor.
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= shifted[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            count <= count + 6'd1;
            if (count == 6'd31) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (div_cancel) begin
            state <= ST_IDLE;
          end else begin
            quotient  <= q_fixed;
            remainder <= r_fixed;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized divides
// compared against a 64-bit arithmetic reference model.
module tb_div_unit;

  logic        div_clk = 1'b0;
  logic        div_rst_n;
  logic        div_start;
  logic        div_signed;
  logic        div_cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_q = 32'd0;
  logic [31:0] prev_r = 32'd0;

  div_unit dut (
    .div_clk    (div_clk),
    .div_rst_n  (div_rst_n),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_cancel (div_cancel),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 div_clk = ~div_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa, sb, lq, lr;
    dbz = 1'b0;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dbz = 1'b1;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Runs one divide starting from the phase just after a rising edge.
  // cancel_at/restart_at/rst_at name the sample index after which the event is applied.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int cancel_at, input int restart_at, input int rst_at);
    logic [31:0] eq, er;
    logic        edbz;
    int          exp_lat;
    int          n;
    bit          seen;
    model(a, b, sgn, eq, er, edbz);
    exp_lat    = (b == 32'd0) ? 1 : 33;
    dividend   = a;
    divisor    = b;
    div_signed = sgn;
    div_start  = 1'b1;
    @(posedge div_clk); #1;
    div_start  = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    div_signed = 1'($urandom_range(0, 1));
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("dbz_cleared_on_accept", {31'd0, div_by_zero}, 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (cancel_at != 0 && n == cancel_at) div_cancel = 1'b1;
      if (restart_at != 0 && n == restart_at) begin
        div_start = 1'b1;
        dividend  = $urandom;
        divisor   = $urandom_range(1, 100);
      end
      @(posedge div_clk); #1;
      n++;
      div_start = 1'b0;
      if (div_cancel) begin
        div_cancel = 1'b0;
        check("cancel_idle", {31'd0, busy}, 32'd0);
        check("cancel_no_done", {31'd0, done}, 32'd0);
        check("cancel_q_kept", quotient, prev_q);
        check("cancel_r_kept", remainder, prev_r);
        return;
      end
      if (rst_at != 0 && n == rst_at) begin
        #2 div_rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        prev_q = 32'd0;
        prev_r = 32'd0;
        #2 div_rst_n = 1'b1;
        return;
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        check("busy_in_flight", {31'd0, busy}, 32'd1);
        check("q_held_in_flight", quotient, prev_q);
        check("r_held_in_flight", remainder, prev_r);
      end
    end
    check("latency", n, exp_lat);
    if (seen) begin
      check("busy_at_done", {31'd0, busy}, 32'd1);
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
      prev_q = eq;
      prev_r = er;
      @(posedge div_clk); #1;
      check("done_pulse_ends", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    div_rst_n  = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_cancel = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge div_clk); #1;
    div_rst_n = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 0, 0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    run_div(32'h0000_1234, 32'd0, 1'b0, 0, 0, 0);
    run_div(32'd50, 32'd5, 1'b0, 0, 0, 0);
    run_div(32'hDEAD_BEEF, 32'd3, 1'b0, 9, 0, 0);
    run_div(32'd1000, 32'd9, 1'b0, 0, 5, 0);
    run_div(32'hFFFF_FF00, 32'd0, 1'b1, 0, 0, 0);
    run_div(32'h1357_9BDF, 32'd11, 1'b1, 32, 0, 0);

    // Simultaneous start and cancel in IDLE must not launch a divide.
    dividend   = 32'd77;
    divisor    = 32'd7;
    div_signed = 1'b0;
    div_start  = 1'b1;
    div_cancel = 1'b1;
    @(posedge div_clk); #1;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    check("start_cancel_ignored", {31'd0, busy}, 32'd0);

    run_div(32'h0F0F_0F0F, 32'd13, 1'b0, 0, 0, 15);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = 32'hFFFF_FFFF;
        3:       begin b = $urandom; a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      run_div(a, b, 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
